// File: rtl/pc_adder.sv
// Branch/jump target adder: PC_IN + (OFFSET << SHIFT) through a 4-bit-group
// carry-lookahead adder with a Kogge-Stone prefix across groups.
module pc_adder #(
    parameter int P     = 32,
    parameter int SHIFT = 2
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [P-1:0] PC_IN,
    input  logic [P-1:0] OFFSET,
    output logic [P-1:0] TARGET_PC,
    output logic [P-1:0] TARGET_PC_Q,
    output logic         OVF,
    output logic         OVF_Q,
    output logic         MISALIGN
);

    localparam int NG = (P + 3) / 4;
    localparam int W  = NG * 4;
    localparam int LV = (NG > 1) ? $clog2(NG) : 0;

    logic [P-1:0]   off_sh;
    logic [SHIFT:0] off_top;
    logic           shift_lost;
    logic [W-1:0]   a_ext;
    logic [W-1:0]   b_ext;
    logic [W-1:0]   bit_g;
    logic [W-1:0]   bit_p;
    logic [NG-1:0]  grp_g;
    logic [NG-1:0]  grp_p;
    logic [NG-1:0]  pfx_g [0:LV];
    logic [NG-1:0]  pfx_p [0:LV];
    logic [W:0]     carry;
    logic [W-1:0]   sum;
    logic           add_ovf;
    logic [P-1:0]   target_d;
    logic [P-1:0]   target_q;
    logic           ovf_d;
    logic           ovf_q;

    // The discarded bits plus the new sign bit must all agree, otherwise the
    // scaled offset no longer represents the original displacement.
    assign off_sh     = OFFSET << SHIFT;
    assign off_top    = OFFSET[P-1 -: SHIFT+1];
    assign shift_lost = ~(&off_top | ~|off_top);

    always_comb begin
        a_ext        = '0;
        b_ext        = '0;
        a_ext[P-1:0] = PC_IN;
        b_ext[P-1:0] = off_sh;
    end

    assign bit_g = a_ext & b_ext;
    assign bit_p = a_ext ^ b_ext;

    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int i = 0; i < NG; i++) begin
            grp_g[i] = bit_g[4*i+3]
                     | (bit_p[4*i+3] & bit_g[4*i+2])
                     | (bit_p[4*i+3] & bit_p[4*i+2] & bit_g[4*i+1])
                     | (bit_p[4*i+3] & bit_p[4*i+2] & bit_p[4*i+1] & bit_g[4*i]);
            grp_p[i] = &bit_p[4*i +: 4];
        end
    end

    // Level l combines each group span with the span 2^(l-1) groups below.
    always_comb begin
        for (int l = 0; l <= LV; l++) begin
            pfx_g[l] = '0;
            pfx_p[l] = '0;
        end
        pfx_g[0] = grp_g;
        pfx_p[0] = grp_p;
        for (int l = 1; l <= LV; l++) begin
            for (int i = 0; i < NG; i++) begin
                if (i >= (1 << (l - 1))) begin
                    pfx_g[l][i] = pfx_g[l-1][i]
                                | (pfx_p[l-1][i] & pfx_g[l-1][i - (1 << (l - 1))]);
                    pfx_p[l][i] = pfx_p[l-1][i] & pfx_p[l-1][i - (1 << (l - 1))];
                end else begin
                    pfx_g[l][i] = pfx_g[l-1][i];
                    pfx_p[l][i] = pfx_p[l-1][i];
                end
            end
        end
    end

    always_comb begin
        carry    = '0;
        carry[0] = 1'b0;
        for (int i = 0; i < NG; i++) begin
            carry[4*i+4] = pfx_g[LV][i];
        end
        for (int i = 0; i < NG; i++) begin
            carry[4*i+1] = bit_g[4*i]
                         | (bit_p[4*i] & carry[4*i]);
            carry[4*i+2] = bit_g[4*i+1]
                         | (bit_p[4*i+1] & bit_g[4*i])
                         | (bit_p[4*i+1] & bit_p[4*i] & carry[4*i]);
            carry[4*i+3] = bit_g[4*i+2]
                         | (bit_p[4*i+2] & bit_g[4*i+1])
                         | (bit_p[4*i+2] & bit_p[4*i+1] & bit_g[4*i])
                         | (bit_p[4*i+2] & bit_p[4*i+1] & bit_p[4*i] & carry[4*i]);
        end
    end

    assign sum     = bit_p ^ carry[W-1:0];
    assign add_ovf = carry[P] ^ carry[P-1];

    assign TARGET_PC = sum[P-1:0];
    assign OVF       = add_ovf | shift_lost;
    assign MISALIGN  = |PC_IN[1:0];

    assign target_d = TARGET_PC;
    assign ovf_d    = OVF;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            target_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            ovf_q    <= ovf_d;
        end
    end

    assign TARGET_PC_Q = target_q;
    assign OVF_Q       = ovf_q;

endmodule

// File: tb/tb_pc_adder.sv
// Self-checking bench for pc_adder: directed literal cases plus randomized
// stimulus compared every cycle against an arithmetic reference model.
module tb_pc_adder;

    localparam int P     = 32;
    localparam int SHIFT = 2;
    localparam longint SMAX = (64'sd1 <<< (P - 1)) - 1;
    localparam longint SMIN = -(64'sd1 <<< (P - 1));

    logic         CLK = 1'b0;
    logic         RESET;
    logic [P-1:0] PC_IN;
    logic [P-1:0] OFFSET;
    logic [P-1:0] TARGET_PC;
    logic [P-1:0] TARGET_PC_Q;
    logic         OVF;
    logic         OVF_Q;
    logic         MISALIGN;

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    pc_adder #(.P(P), .SHIFT(SHIFT)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PC_IN       (PC_IN),
        .OFFSET      (OFFSET),
        .TARGET_PC   (TARGET_PC),
        .TARGET_PC_Q (TARGET_PC_Q),
        .OVF         (OVF),
        .OVF_Q       (OVF_Q),
        .MISALIGN    (MISALIGN)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: true signed arithmetic in 64 bits, then range tests.
    function automatic logic [P:0] model(input logic [P-1:0] pc, input logic [P-1:0] off);
        logic [P-1:0] sh;
        longint       scaled;
        longint       total;
        bit           lost;
        bit           aovf;
        sh     = off << SHIFT;
        scaled = longint'($signed(off)) * (64'sd1 <<< SHIFT);
        lost   = (scaled != longint'($signed(sh)));
        total  = longint'($signed(pc)) + longint'($signed(sh));
        aovf   = (total > SMAX) || (total < SMIN);
        return {lost | aovf, pc + sh};
    endfunction

    logic [P-1:0] exp_tq;
    logic         exp_oq;
    bit           q_valid = 1'b0;

    always @(posedge CLK) begin
        if (RESET) begin
            exp_tq  = '0;
            exp_oq  = 1'b0;
            q_valid = 1'b1;
        end else begin
            {exp_oq, exp_tq} = model(PC_IN, OFFSET);
        end
    end

    always @(negedge CLK) begin
        logic [P:0] m;
        if (run) begin
            m = model(PC_IN, OFFSET);
            chk("target_pc", 64'(TARGET_PC), 64'(m[P-1:0]));
            chk("ovf", 64'(OVF), 64'(m[P]));
            chk("misalign", 64'(MISALIGN), 64'(PC_IN[1:0] != 2'b00));
            if (q_valid) begin
                chk("target_pc_q", 64'(TARGET_PC_Q), 64'(exp_tq));
                chk("ovf_q", 64'(OVF_Q), 64'(exp_oq));
            end
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] off;
        logic [31:0] tgt;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{32'h0000_0008, 32'h0000_0003, 32'h0000_0014, 1'b0});
        vecs.push_back('{32'h0000_0010, 32'hFFFF_FFFE, 32'h0000_0008, 1'b0});
        vecs.push_back('{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b0});
        vecs.push_back('{32'h7FFF_FFFC, 32'h0000_0001, 32'h8000_0000, 1'b1});
        vecs.push_back('{32'h1234_5678, 32'h4000_0000, 32'h1234_5678, 1'b1});
        vecs.push_back('{32'hDEAD_BEE0, 32'h0000_0000, 32'hDEAD_BEE0, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 1'b1});
        vecs.push_back('{32'h0000_0000, 32'h2000_0000, 32'h8000_0000, 1'b1});
        vecs.push_back('{32'hFFFF_FFF0, 32'h0000_0008, 32'h0000_0010, 1'b0});

        RESET  = 1'b1;
        PC_IN  = '0;
        OFFSET = '0;
        run    = 1'b1;
        @(posedge CLK); #1;
        chk("reset_target_q", 64'(TARGET_PC_Q), 64'h0);
        chk("reset_ovf_q", 64'(OVF_Q), 64'h0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        foreach (vecs[i]) begin
            PC_IN  = vecs[i].pc;
            OFFSET = vecs[i].off;
            @(negedge CLK); #1;
            chk($sformatf("dir%0d_target", i), 64'(TARGET_PC), 64'(vecs[i].tgt));
            chk($sformatf("dir%0d_ovf", i), 64'(OVF), 64'(vecs[i].ovf));
            @(posedge CLK); #1;
            chk($sformatf("dir%0d_target_q", i), 64'(TARGET_PC_Q), 64'(vecs[i].tgt));
            chk($sformatf("dir%0d_ovf_q", i), 64'(OVF_Q), 64'(vecs[i].ovf));
        end

        PC_IN  = 32'h0000_0006;
        OFFSET = 32'h0000_0001;
        #2;
        chk("misalign_6", 64'(MISALIGN), 64'h1);

        // Mid-stream reset with live inputs.
        PC_IN  = 32'h0000_0008;
        OFFSET = 32'h0000_0003;
        RESET  = 1'b1;
        @(posedge CLK); #1;
        chk("midreset_target_q", 64'(TARGET_PC_Q), 64'h0);
        chk("midreset_ovf_q", 64'(OVF_Q), 64'h0);
        chk("midreset_target", 64'(TARGET_PC), 64'h14);
        chk("midreset_misalign", 64'(MISALIGN), 64'h0);
        RESET = 1'b0;
        @(posedge CLK); #1;
        chk("resume_target_q", 64'(TARGET_PC_Q), 64'h14);

        for (int n = 0; n < 3000; n++) begin
            PC_IN = $urandom();
            case ($urandom_range(0, 3))
                0:       OFFSET = 32'($signed($urandom_range(0, 64)) - 32);
                1:       OFFSET = {{3{$urandom_range(0, 1) == 1}}, 29'($urandom())};
                default: OFFSET = $urandom();
            endcase
            if ($urandom_range(0, 15) == 0) PC_IN = 32'h7FFF_FFF0 + 32'($urandom_range(0, 31));
            RESET = ($urandom_range(0, 49) == 0);
            @(posedge CLK); #1;
        end

        RESET = 1'b0;
        @(negedge CLK); #1;
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_adder.md
PC_ADDER -- requirements
Module: pc_adder

Interface
REQ-001 Parameter P, default 32: datapath width in bits of all address and offset ports.
REQ-002 Parameter SHIFT, default 2: left-shift applied to the offset before addition (word-to-byte scaling).
REQ-003 CLK  input  1  clock; all registered outputs update on its rising edge only.
REQ-004 RESET  input  1  reset, synchronous, active-high; clock CLK.
REQ-005 PC_IN  input  P  base address, already incremented (PC+4) by the PC unit.
REQ-006 OFFSET  input  P  sign-extended word offset (branch or jump displacement), two's complement.
REQ-007 TARGET_PC  output  P  combinational branch/jump target.
REQ-008 TARGET_PC_Q  output  P  registered copy of TARGET_PC.
REQ-009 OVF  output  1  combinational signed-overflow flag of the addition.
REQ-010 OVF_Q  output  1  registered copy of OVF.
REQ-011 MISALIGN  output  1  combinational flag, high when PC_IN[1:0] is not 2'b00.

Function
REQ-012 TARGET_PC SHALL equal (PC_IN + (OFFSET << SHIFT)) modulo 2^P, with bits shifted out of the top discarded and zeros shifted in.
REQ-013 The shifted offset SHALL be treated as two's complement, so a negative OFFSET produces a backward target.
REQ-014 TARGET_PC, OVF and MISALIGN SHALL be purely combinational, settle within the same cycle and have no dependence on CLK or RESET.
REQ-015 OVF SHALL be high when PC_IN and the shifted offset have equal sign bits and TARGET_PC's sign bit differs from them.
REQ-016 OVF SHALL also be high when the SHIFT left shift discards any bit that differs from the resulting sign bit, i.e. the offset magnitude is lost.
REQ-017 Wrap-around SHALL NOT be saturated: the result wraps modulo 2^P, and only OVF reports it.
REQ-018 OFFSET = 0 SHALL yield TARGET_PC = PC_IN with OVF = 0.
REQ-019 When RESET is low, TARGET_PC_Q and OVF_Q SHALL load TARGET_PC and OVF on every rising CLK edge (latency of one cycle).
REQ-020 Input changes between clock edges SHALL affect only the combinational outputs until the next rising edge.
REQ-021 The adder SHALL be implemented as a carry-lookahead or prefix structure built from 4-bit groups, with no behavioural dependence on the implementation choice.

Reset
REQ-022 On a rising CLK edge with RESET high, TARGET_PC_Q SHALL become 0 and OVF_Q SHALL become 0.
REQ-023 RESET SHALL NOT force or affect TARGET_PC, OVF or MISALIGN.
REQ-024 If RESET is asserted mid-stream, the registered outputs SHALL clear at that edge and resume tracking on the first edge after RESET is deasserted.
REQ-025 Before the first reset edge, the registered outputs SHALL be unspecified.

Verification
REQ-026 Forward branch: PC_IN=0x00000008, OFFSET=0x00000003 -> TARGET_PC=0x00000014, OVF=0; TARGET_PC_Q=0x00000014 after the next edge.
REQ-027 Backward branch: PC_IN=0x00000010, OFFSET=0xFFFFFFFE -> TARGET_PC=0x00000008, OVF=0.
REQ-028 Wrap from the reset PC: PC_IN=0x00000000 (reset value 0xFFFFFFFC plus 4), OFFSET=0xFFFFFFFF -> TARGET_PC=0xFFFFFFFC, OVF=0.
REQ-029 Signed overflow: PC_IN=0x7FFFFFFC, OFFSET=0x00000001 -> TARGET_PC=0x80000000, OVF=1.
REQ-030 Shift loss: OFFSET=0x40000000 -> OVF=1 regardless of PC_IN.
REQ-031 Reset and misalignment: RESET high for one edge with inputs active -> TARGET_PC_Q=0 and OVF_Q=0 while TARGET_PC still tracks the inputs; PC_IN=0x00000006 -> MISALIGN=1.
